// File: rtl/service_dispatcher.sv
// ---------------------------------------------------------------------------
// service_dispatcher
//
// Two independent service lanes (car-wash and workshop). Each lane turns a
// button press into a queued job carrying a 4-bit option code, then launches
// queued jobs one at a time towards its service FSM and waits for that FSM
// to report completion before launching the next one.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   PB1 / PB2  car-wash / workshop request buttons (level)
//   C / T      option codes captured on the button's rising edge
//   CT / CT1   service-complete flags from the car-wash / workshop FSMs
//   GO / GO1   one-cycle start pulses
//   CO / TO    option code of the last launched job, held until next launch
//   QC / QT    current queue occupancy per lane
//   FULL/FULL1 queue full per lane
//   ERR        sticky flag: some request was rejected since reset
// ---------------------------------------------------------------------------
module service_dispatcher #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PB1,
  input  logic       PB2,
  input  logic [3:0] C,
  input  logic [3:0] T,
  input  logic       CT,
  input  logic       CT1,
  output logic       GO,
  output logic       GO1,
  output logic [3:0] CO,
  output logic [3:0] TO,
  output logic [3:0] QC,
  output logic [3:0] QT,
  output logic       FULL,
  output logic       FULL1,
  output logic       ERR
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // Lane 0 = car-wash, lane 1 = workshop.
  logic [1:0] pb_w;
  logic [1:0] ct_w;
  logic [1:0] go_w;
  logic [1:0] full_w;
  logic [1:0] reject_w;
  logic [3:0] code_w [2];
  logic [3:0] out_w  [2];
  logic [3:0] cnt_w  [2];
  logic       err_q;

  assign pb_w      = {PB2, PB1};
  assign ct_w      = {CT1, CT};
  assign code_w[0] = C;
  assign code_w[1] = T;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic          pb_q;
      logic          arm_q;
      logic [3:0]    mem_q [DEPTH];
      logic [PW-1:0] wr_q;
      logic [PW-1:0] rd_q;
      logic [3:0]    cnt_q;
      logic [3:0]    cnt_d;
      logic [1:0]    st_q;
      logic [1:0]    st_d;
      logic [3:0]    out_q;
      logic          rise_w;
      logic          full_l;
      logic          pop_w;
      logic          push_w;

      // arm_q stays low while the button is still held from before reset
      // release, so a press that straddles reset never becomes a request.
      assign rise_w = pb_w[gi] & ~pb_q & arm_q;
      assign full_l = (cnt_q == DEPTH_L);
      assign pop_w  = (st_q == ST_IDLE) && (cnt_q != 4'd0);
      // A pop in the same cycle frees a slot, so a full queue still accepts.
      assign push_w = rise_w && (code_w[gi] != 4'd0) && (!full_l || pop_w);
      assign reject_w[gi] = rise_w && !push_w;

      always_comb begin
        cnt_d = cnt_q;
        case ({push_w, pop_w})
          2'b10:   cnt_d = cnt_q + 4'd1;
          2'b01:   cnt_d = cnt_q - 4'd1;
          default: cnt_d = cnt_q;
        endcase
      end

      always_comb begin
        st_d = st_q;
        case (st_q)
          ST_IDLE:   if (cnt_q != 4'd0) st_d = ST_LAUNCH;
          ST_LAUNCH: st_d = ST_WAIT;
          ST_WAIT:   if (ct_w[gi]) st_d = ST_IDLE;
          default:   st_d = ST_IDLE;
        endcase
      end

      // Storage array kept free of reset so it maps onto RAM; stale
      // contents are harmless because the pointers are cleared.
      always_ff @(posedge clk) begin
        if (push_w) mem_q[wr_q] <= code_w[gi];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          pb_q  <= 1'b0;
          arm_q <= ~pb_w[gi];
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= 4'd0;
          st_q  <= ST_IDLE;
          out_q <= 4'd0;
        end else begin
          pb_q  <= pb_w[gi];
          arm_q <= arm_q | ~pb_w[gi];
          cnt_q <= cnt_d;
          st_q  <= st_d;
          if (push_w) wr_q <= wr_q + 1'b1;
          if (pop_w) begin
            rd_q  <= rd_q + 1'b1;
            out_q <= mem_q[rd_q];
          end
        end
      end

      assign go_w[gi]   = (st_q == ST_LAUNCH);
      assign full_w[gi] = full_l;
      assign out_w[gi]  = out_q;
      assign cnt_w[gi]  = cnt_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | (|reject_w);
  end

  assign GO    = go_w[0];
  assign GO1   = go_w[1];
  assign CO    = out_w[0];
  assign TO    = out_w[1];
  assign QC    = cnt_w[0];
  assign QT    = cnt_w[1];
  assign FULL  = full_w[0];
  assign FULL1 = full_w[1];
  assign ERR   = err_q;

endmodule

// File: tb/tb_service_dispatcher.sv
module tb_service_dispatcher;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       PB1, PB2;
  logic [3:0] C, T;
  logic       CT, CT1;
  logic       GO, GO1;
  logic [3:0] CO, TO, QC, QT;
  logic       FULL, FULL1, ERR;

  service_dispatcher #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .PB1(PB1), .PB2(PB2), .C(C), .T(T),
    .CT(CT), .CT1(CT1), .GO(GO), .GO1(GO1), .CO(CO), .TO(TO),
    .QC(QC), .QT(QT), .FULL(FULL), .FULL1(FULL1), .ERR(ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each lane: a list of waiting codes, a "lane busy" flag set when a job
  // is taken, and the job is finished by the first completion flag seen at
  // least two edges after it was taken (the launch cycle ignores it).
  logic [3:0] pend [2][$];
  logic [3:0] sb   [2][$];
  bit         busy     [2];
  int         taken_at [2];
  bit         go_due   [2];
  logic [3:0] last_code[2];
  bit         prev_b   [2];
  bit         seen_low [2];
  bit         err_m;
  bit         started = 0;
  int         cyc = 0;

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      bit         btn, ctf, rise, take;
      logic [3:0] code, c;
      int         sz;
      btn  = (l == 0) ? PB1 : PB2;
      ctf  = (l == 0) ? CT  : CT1;
      code = (l == 0) ? C   : T;
      if (reset) begin
        pend[l].delete();
        sb[l].delete();
        busy[l]      = 0;
        go_due[l]    = 0;
        last_code[l] = 4'd0;
        prev_b[l]    = 0;
        seen_low[l]  = !btn;
      end else begin
        sz   = pend[l].size();
        take = !busy[l] && (sz > 0);
        rise = btn && !prev_b[l] && seen_low[l];
        go_due[l] = take;
        if (take) begin
          c = pend[l].pop_front();
          sb[l].push_back(c);
          last_code[l] = c;
          busy[l]      = 1;
          taken_at[l]  = cyc;
        end else if (busy[l] && ctf && (cyc >= taken_at[l] + 2)) begin
          busy[l] = 0;
        end
        if (rise) begin
          if (code != 4'd0 && (sz < DEPTH || take)) pend[l].push_back(code);
          else err_m = 1;
        end
        prev_b[l] = btn;
        if (!btn) seen_low[l] = 1;
      end
    end
    if (reset) begin
      err_m   = 0;
      started = 1;
    end
    cyc++;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("GO",    {7'd0, GO},    {7'd0, go_due[0]});
      chk("GO1",   {7'd0, GO1},   {7'd0, go_due[1]});
      chk("QC",    {4'd0, QC},    8'(pend[0].size()));
      chk("QT",    {4'd0, QT},    8'(pend[1].size()));
      chk("FULL",  {7'd0, FULL},  {7'd0, pend[0].size() == DEPTH});
      chk("FULL1", {7'd0, FULL1}, {7'd0, pend[1].size() == DEPTH});
      chk("ERR",   {7'd0, ERR},   {7'd0, err_m});
      chk("CO",    {4'd0, CO},    {4'd0, last_code[0]});
      chk("TO",    {4'd0, TO},    {4'd0, last_code[1]});
      for (int l = 0; l < 2; l++) begin
        logic go_l;
        logic [3:0] code_l, e;
        go_l   = (l == 0) ? GO : GO1;
        code_l = (l == 0) ? CO : TO;
        if (go_l === 1'b1) begin
          if (sb[l].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL launch_%0d: got start pulse code %h expected no pulse", l, code_l);
          end else begin
            e = sb[l].pop_front();
            chk((l == 0) ? "CO_job" : "TO_job", {4'd0, code_l}, {4'd0, e});
            $display("lane %0d launch code %h (expected %h) t=%0t", l, code_l, e, $time);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press1(input logic [3:0] code, input int hold);
    C = code; PB1 = 1'b1; cyc_n(hold); PB1 = 1'b0; cyc_n(1);
  endtask

  task automatic press2(input logic [3:0] code, input int hold);
    T = code; PB2 = 1'b1; cyc_n(hold); PB2 = 1'b0; cyc_n(1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; cyc_n(n); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; PB1 = 0; PB2 = 0; C = 0; T = 0; CT = 0; CT1 = 0;
    cyc_n(3);
    reset = 1'b0;
    cyc_n(2);

    // single job on car-wash lane
    press1(4'b1000, 1);
    cyc_n(4);
    CT = 1; cyc_n(1); CT = 0; cyc_n(3);

    // workshop fill / overflow, then release jobs one by one
    for (int i = 1; i <= 6; i++) press2(4'(i), 1);
    cyc_n(3);
    for (int i = 0; i < 4; i++) begin
      CT1 = 1; cyc_n(1); CT1 = 0; cyc_n(4);
    end
    CT1 = 1; cyc_n(1); CT1 = 0;
    do_reset(1); cyc_n(2);

    // zero option code is rejected and ERR sticks
    press1(4'b0000, 1);
    cyc_n(6);
    do_reset(1); cyc_n(2);

    // simultaneous presses on both lanes
    C = 4'b0001; T = 4'b0001; PB1 = 1; PB2 = 1; cyc_n(1); PB1 = 0; PB2 = 0;
    cyc_n(4);
    CT = 1; CT1 = 1; cyc_n(1); CT = 0; CT1 = 0; cyc_n(2);

    // held button produces a single request
    press1(4'b0010, 10);
    cyc_n(3);
    CT = 1; cyc_n(1); CT = 0; cyc_n(2);

    // reset while waiting with two more jobs queued
    press1(4'd1, 1); press1(4'd2, 1); press1(4'd3, 1);
    cyc_n(2);
    do_reset(1);
    cyc_n(6);

    // button held across reset release
    PB1 = 1; C = 4'd7; do_reset(2);
    cyc_n(3); PB1 = 0; cyc_n(2);
    press1(4'd9, 1);
    cyc_n(3); CT = 1; cyc_n(1); CT = 0; cyc_n(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 150) % 3;
      PB1 = ($urandom_range(0, 2) == 0);
      PB2 = ($urandom_range(0, 2) == 0);
      C   = 4'($urandom_range(0, 15));
      T   = 4'($urandom_range(0, 15));
      CT  = (mode == 0) ? 1'b0 : ($urandom_range(0, mode * 2) == 0);
      CT1 = (mode == 1) ? 1'b0 : ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 249) == 0);
      cyc_n(1);
    end
    reset = 0;

    // drain both lanes
    PB1 = 0; PB2 = 0; CT = 1; CT1 = 1;
    cyc_n(40);
    chk("drain_q0",  8'(pend[0].size() + sb[0].size()), 8'd0);
    chk("drain_q1",  8'(pend[1].size() + sb[1].size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/service_dispatcher.md
SERVICE_DISPATCHER -- requirements
Module: service_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per lane queue (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port PB1, input, 1, car-wash request button (level, held any number of cycles).
REQ-005 SHALL have port PB2, input, 1, workshop request button (level).
REQ-006 SHALL have port C, input, 4, car-wash option code sampled with PB1 rising edge.
REQ-007 SHALL have port T, input, 4, workshop option code sampled with PB2 rising edge.
REQ-008 SHALL have port CT, input, 1, car-wash service-complete flag from the service FSM.
REQ-009 SHALL have port CT1, input, 1, workshop service-complete flag from the service FSM.
REQ-010 SHALL have port GO, output, 1, one-cycle start pulse to car-wash service.
REQ-011 SHALL have port GO1, output, 1, one-cycle start pulse to workshop service.
REQ-012 SHALL have port CO, output, 4, option code presented with GO, held until next GO.
REQ-013 SHALL have port TO, output, 4, option code presented with GO1, held until next GO1.
REQ-014 SHALL have ports QC and QT, output, 4 each, current occupancy of car-wash and workshop queues.
REQ-015 SHALL have ports FULL, FULL1, ERR, output, 1 each: car-wash queue full, workshop queue full, sticky request-rejected flag.

Function
REQ-016 Request edge: rising edge = button high this cycle, low previous cycle (registered); holding button SHALL create exactly one request.
REQ-017 Accepted request SHALL push option code into its lane FIFO; occupancy visible on QC/QT the following cycle.
REQ-018 Request with option code 4'b0000 SHALL be rejected (no push) and set ERR.
REQ-019 Request while lane queue full and no pop in same cycle SHALL be rejected and set ERR; occupancy unchanged.
REQ-020 Push and pop in same cycle on a full queue SHALL both succeed; occupancy unchanged.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; order strictly first-in first-out.
REQ-022 Each lane SHALL run an independent FSM: IDLE, LAUNCH, WAIT.
REQ-023 IDLE -> LAUNCH when queue non-empty; pop occurs on this transition.
REQ-024 LAUNCH: GO (or GO1) high exactly one cycle, CO (or TO) = popped code; -> WAIT next cycle.
REQ-025 WAIT -> IDLE on first cycle CT (or CT1) sampled high; CT high in IDLE or LAUNCH SHALL be ignored.
REQ-026 Minimum spacing between two GO pulses on one lane SHALL be 3 cycles (LAUNCH, WAIT, IDLE).
REQ-027 Lanes SHALL not interact; PB1 and PB2 edges in same cycle SHALL both be accepted.
REQ-028 FULL = (QC == DEPTH), FULL1 = (QT == DEPTH), combinationally from registered occupancy.
REQ-029 ERR SHALL remain high until reset.

Reset
REQ-030 reset high at a clock edge SHALL clear both FIFOs, QC=QT=0, FULL=FULL1=0, ERR=0, GO=GO1=0, CO=TO=4'b0000, both FSMs to IDLE, button edge registers to 0.
REQ-031 Reset mid-service (in WAIT) SHALL abandon the job; no GO issued for it after reset.
REQ-032 Button held high across reset release SHALL not create a request until released and pressed again.

Verification
REQ-033 Single job: PB1 edge with C=4'b1000, CT idle -> QC=1 next cycle, GO pulse with CO=1000 two cycles after edge, QC=0; CT pulse -> lane back to IDLE.
REQ-034 Fill/overflow (DEPTH=4, CT held low): five PB2 edges with T=1,2,3,4,5 -> GO1 with TO=1 issued, QT reaches 3 then 4 (FULL1=1) then sixth edge sets ERR; then CT1 pulses release TO=2,3,4,5 in order, each GO1 >=3 cycles apart.
REQ-035 Zero option: PB1 edge with C=0 -> QC stays 0, no GO, ERR=1 until reset.
REQ-036 Simultaneous: PB1 and PB2 rise same cycle, C=0001, T=0001 -> GO and GO1 both pulse in same cycle.
REQ-037 Held button: PB1 high 10 cycles, C=0010 -> exactly one push, one GO.
REQ-038 Reset mid-WAIT with QC=2 -> all outputs at reset values next cycle, no further GO without new requests.
